// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port scheduler: FSM state encoding,
// one-hot engine-select encoding and default geometry/timing constants.
package sdram_pkg;

  typedef enum logic [2:0] {
    INIT_START,
    INIT_WAIT,
    IDLE,
    REF_START,
    REF_WAIT,
    OP_START,
    OP_WAIT,
    DONE
  } state_e;

  // One-hot bus ownership, bit order {ref, rd, wr, init}.
  typedef enum logic [3:0] {
    ENG_INIT = 4'b0001,
    ENG_WR   = 4'b0010,
    ENG_RD   = 4'b0100,
    ENG_REF  = 4'b1000
  } eng_sel_e;

  localparam int DEF_NPORTS       = 2;
  localparam int DEF_BANK_W       = 2;
  localparam int DEF_ROW_W        = 13;
  localparam int DEF_COL_W        = 10;
  localparam int DEF_DATA_W       = 128;
  localparam int DEF_REF_INTERVAL = 780;
  localparam int DEF_MAX_PEND     = 7;

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Round-robin port selector: searches upward from the port after the last
// grant, wrapping at NPORTS, and returns the first requesting port.
module sdram_rr_arbiter #(
  parameter int NPORTS = 2
) (
  input  logic [NPORTS-1:0]         req,
  input  logic [$clog2(NPORTS)-1:0] last_grant,
  output logic [$clog2(NPORTS)-1:0] grant,
  output logic                      valid
);

  localparam int IDX_W = $clog2(NPORTS);

  logic [IDX_W-1:0] cand;

  // First requester at or after last_grant+1 (mod NPORTS); last_grant itself is checked last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NPORTS);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Multi-port SDRAM front end: runs initialisation, then arbitrates client
// bursts round-robin onto the read/write engines, with refresh taking
// priority whenever a refresh is owed. All outputs come straight from flops.
module sdram_port_scheduler
  import sdram_pkg::*;
#(
  parameter int NPORTS       = DEF_NPORTS,
  parameter int BANK_W       = DEF_BANK_W,
  parameter int ROW_W        = DEF_ROW_W,
  parameter int COL_W        = DEF_COL_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int REF_INTERVAL = DEF_REF_INTERVAL,
  parameter int MAX_PEND     = DEF_MAX_PEND
) (
  input  logic                                     iclk,
  input  logic                                     ireset_n,
  input  logic [NPORTS-1:0]                        ireq,
  input  logic [NPORTS-1:0]                        iwe,
  input  logic [NPORTS*(BANK_W+ROW_W+COL_W-3)-1:0] iaddr,
  input  logic [NPORTS*DATA_W-1:0]                 iwdata,
  output logic [NPORTS-1:0]                        oack,
  output logic [NPORTS*DATA_W-1:0]                 ordata,
  output logic                                     oinit_req,
  output logic                                     owr_req,
  output logic                                     ord_req,
  output logic                                     oref_req,
  output logic [3:0]                               oengine_sel,
  output logic [BANK_W-1:0]                        obank,
  output logic [ROW_W-1:0]                         orow,
  output logic [COL_W-1:0]                         ocol,
  output logic [DATA_W-1:0]                        owdata,
  input  logic [DATA_W-1:0]                        ird_data,
  input  logic                                     iinit_fin,
  input  logic                                     iwr_fin,
  input  logic                                     ird_fin,
  input  logic                                     iref_fin,
  output logic                                     orefresh_miss
);

  localparam int AW     = BANK_W + ROW_W + COL_W - 3;
  localparam int IDX_W  = $clog2(NPORTS);
  localparam int TMR_W  = $clog2(REF_INTERVAL + 1);
  localparam int PEND_W = $clog2(MAX_PEND + 1);

  state_e                   state_q, state_d;
  eng_sel_e                 sel_q, sel_d;
  logic [IDX_W-1:0]         gnt_q, gnt_d, last_q, last_d, arb_gnt;
  logic                     arb_valid;
  logic                     we_q, we_d;
  logic [BANK_W-1:0]        bank_q, bank_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-4:0]         col_q, col_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [NPORTS*DATA_W-1:0] rdata_q, rdata_d;
  logic [NPORTS-1:0]        ack_q, ack_d;
  logic                     init_req_q, init_req_d, wr_req_q, wr_req_d;
  logic                     rd_req_q, rd_req_d, ref_req_q, ref_req_d;
  logic [TMR_W-1:0]         timer_q, timer_d;
  logic [PEND_W-1:0]        pend_q, pend_d;
  logic                     miss_q, miss_d, init_done_q, init_done_d;
  logic                     tmr_expire, ref_done;
  logic [AW-1:0]            op_addr;

  assign op_addr = iaddr[int'(gnt_q)*AW +: AW];

  sdram_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
    .req        (ireq),
    .last_grant (last_q),
    .grant      (arb_gnt),
    .valid      (arb_valid)
  );

  // State register.
  always_ff @(posedge iclk or negedge ireset_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (!ireset_n) state_q <= INIT_START;
    else           state_q <= state_d;
  end

  // Next-state logic: refresh outranks ports in IDLE; engines finish the WAIT states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT_START: state_d = INIT_WAIT;
      INIT_WAIT:  if (iinit_fin) state_d = IDLE;
      IDLE: begin
        if (pend_q != '0)   state_d = REF_START;
        else if (arb_valid) state_d = OP_START;
      end
      REF_START:  state_d = REF_WAIT;
      REF_WAIT:   if (iref_fin) state_d = IDLE;
      OP_START:   state_d = OP_WAIT;
      OP_WAIT:    if (we_q ? iwr_fin : ird_fin) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = INIT_START;
    endcase
  end

  // Output/datapath next values: start pulses, grant and burst latching, read capture, ack.
  always_comb begin
    ack_d      = '0;
    init_req_d = 1'b0;
    wr_req_d   = 1'b0;
    rd_req_d   = 1'b0;
    ref_req_d  = 1'b0;
    gnt_d      = gnt_q;
    last_d     = last_q;
    we_d       = we_q;
    bank_d     = bank_q;
    row_d      = row_q;
    col_d      = col_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      INIT_START: init_req_d = 1'b1;
      IDLE:       if (pend_q == '0 && arb_valid) gnt_d = arb_gnt;
      REF_START:  ref_req_d = 1'b1;
      OP_START: begin
        we_d     = iwe[gnt_q];
        bank_d   = op_addr[AW-1 -: BANK_W];
        row_d    = op_addr[COL_W-3 +: ROW_W];
        col_d    = op_addr[COL_W-4:0];
        wdata_d  = iwdata[int'(gnt_q)*DATA_W +: DATA_W];
        wr_req_d = iwe[gnt_q];
        rd_req_d = !iwe[gnt_q];
      end
      OP_WAIT: begin
        if (we_q && iwr_fin) ack_d[gnt_q] = 1'b1;
        if (!we_q && ird_fin) begin
          ack_d[gnt_q] = 1'b1;
          rdata_d[int'(gnt_q)*DATA_W +: DATA_W] = ird_data;
        end
      end
      DONE:       last_d = gnt_q;
      default:    ;
    endcase
    // Bus owner follows the state being entered so it lines up with the registered state.
    case (state_d)
      REF_START, REF_WAIT: sel_d = ENG_REF;
      OP_START:            sel_d = iwe[gnt_d] ? ENG_WR : ENG_RD;
      OP_WAIT, DONE:       sel_d = we_d ? ENG_WR : ENG_RD;
      default:             sel_d = ENG_INIT;
    endcase
  end

  // Refresh bookkeeping: interval timer after init, backlog count with saturation.
  always_comb begin
    init_done_d = init_done_q | ((state_q == INIT_WAIT) & iinit_fin);
    tmr_expire  = init_done_q && (timer_q == TMR_W'(1));
    ref_done    = (state_q == REF_WAIT) && iref_fin;
    timer_d     = timer_q;
    if (init_done_q) timer_d = tmr_expire ? TMR_W'(REF_INTERVAL) : timer_q - TMR_W'(1);
    pend_d = pend_q;
    miss_d = miss_q;
    if (tmr_expire && !ref_done) begin
      if (pend_q == PEND_W'(MAX_PEND)) miss_d = 1'b1;
      else                             pend_d = pend_q + PEND_W'(1);
    end else if (ref_done && !tmr_expire) begin
      pend_d = pend_q - PEND_W'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      sel_q      <= ENG_INIT;
      gnt_q      <= '0;
      last_q     <= IDX_W'(NPORTS - 1);
      we_q       <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wdata_q    <= '0;
      // NOTE: the read-data bank is reset deliberately; clients may look at ordata before their first read.
      rdata_q    <= '0;
      ack_q      <= '0;
      init_req_q <= 1'b0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      ref_req_q  <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      init_req_q <= init_req_d;
      wr_req_q   <= wr_req_d;
      rd_req_q   <= rd_req_d;
      ref_req_q  <= ref_req_d;
    end
  end

  // Refresh timer and backlog registers.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      timer_q     <= TMR_W'(REF_INTERVAL);
      pend_q      <= '0;
      miss_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      miss_q      <= miss_d;
      init_done_q <= init_done_d;
    end
  end

  assign oack          = ack_q;
  assign ordata        = rdata_q;
  assign oinit_req     = init_req_q;
  assign owr_req       = wr_req_q;
  assign ord_req       = rd_req_q;
  assign oref_req      = ref_req_q;
  assign oengine_sel   = sel_q;
  assign obank         = bank_q;
  assign orow          = row_q;
  assign ocol          = {col_q, 3'b000};
  assign owdata        = wdata_q;
  assign orefresh_miss = miss_q;

endmodule

// File: doc/sdram_port_scheduler.md
SDRAM_PORT_SCHEDULER -- requirements
Module: sdram_port_scheduler

Interface
REQ-001 Parameters SHALL be: NPORTS, 2, number of client ports (2..8); BANK_W, 2, bank address width; ROW_W, 13, row address width; COL_W, 10, column address width; DATA_W, 128, burst data width; REF_INTERVAL, 780, cycles between refresh requests; MAX_PEND, 7, refresh backlog limit.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 iclk  in  1  clock; all state changes on its rising edge.
REQ-004 ireset_n  in  1  asynchronous active-low reset.
REQ-005 ireq  in  NPORTS  per-port request, held high until matching oack.
REQ-006 iwe  in  NPORTS  per-port direction: 1 write, 0 read.
REQ-007 iaddr  in  NPORTS*(BANK_W+ROW_W+COL_W-3)  per-port burst address {bank,row,col[COL_W-1:3]}.
REQ-008 iwdata  in  NPORTS*DATA_W  per-port write burst.
REQ-009 oack  out  NPORTS  one-cycle completion pulse per port.
REQ-010 ordata  out  NPORTS*DATA_W  per-port read burst, valid from oack onward until that port's next read completes.
REQ-011 oinit_req, owr_req, ord_req, oref_req  out  1 each  one-cycle start pulses to init/write/read/refresh engines.
REQ-012 oengine_sel  out  4  one-hot bus ownership {ref,rd,wr,init}, exactly one bit set at all times.
REQ-013 obank, orow, ocol  out  BANK_W/ROW_W/COL_W  latched target; ocol[2:0] always 0.
REQ-014 owdata  out  DATA_W  latched write burst; ird_data  in  DATA_W  read engine result.
REQ-015 iinit_fin, iwr_fin, ird_fin, iref_fin  in  1 each  engine completion pulses.
REQ-016 orefresh_miss  out  1  sticky: refresh backlog overflowed.

Function
REQ-017 FSM states SHALL be INIT_START, INIT_WAIT, IDLE, REF_START, REF_WAIT, OP_START, OP_WAIT, DONE; all outputs registered.
REQ-018 INIT_START -> INIT_WAIT unconditionally, pulsing oinit_req; INIT_WAIT -> IDLE on iinit_fin.
REQ-019 IDLE: refresh pending count > 0 -> REF_START (priority over all ports); else any ireq -> OP_START with round-robin grant; else stay.
REQ-020 Round-robin: search starts at port (last_grant+1) mod NPORTS; last_grant resets to NPORTS-1 so port 0 wins first.
REQ-021 OP_START latches granted port index, iwe, address and iwdata, pulses owr_req or ord_req, sets oengine_sel, -> OP_WAIT.
REQ-022 OP_WAIT -> DONE on iwr_fin (write) or ird_fin (read); on ird_fin ird_data is captured into granted port's ordata slice.
REQ-023 DONE pulses oack for granted port only, updates last_grant, -> IDLE; total latency ireq-to-oack = engine latency + 3 cycles minimum.
REQ-024 REF_START pulses oref_req, -> REF_WAIT; REF_WAIT -> IDLE on iref_fin, decrementing pending count.
REQ-025 Refresh timer runs only after init completes; counts REF_INTERVAL cycles, then increments pending count and reloads.
REQ-026 Timer expiry and refresh completion in the same cycle SHALL leave pending count unchanged.
REQ-027 Expiry with pending count = MAX_PEND SHALL hold count at MAX_PEND and set orefresh_miss.
REQ-028 oengine_sel defaults to init in INIT states and IDLE; holds wr/rd/ref from *_START through DONE/REF_WAIT.
REQ-029 A port holding ireq high the cycle after oack SHALL be treated as a new request; ireq deasserted before grant is not served.
REQ-030 fin pulses arriving outside their WAIT state SHALL be ignored.

Reset
REQ-031 ireset_n low SHALL asynchronously force state INIT_START, oack=0, all *_req=0, oengine_sel=0001, pending=0, timer=REF_INTERVAL, orefresh_miss=0, last_grant=NPORTS-1, ordata=0, obank/orow/ocol/owdata=0.
REQ-032 Reset mid-operation SHALL abandon the transfer without oack and re-run initialisation.

Structure
REQ-033 Shared package sdram_pkg SHALL hold state encoding, engine-select encoding and default geometry constants.
REQ-034 Round-robin selection SHALL be sub-module sdram_rr_arbiter (NPORTS, request vector, last grant -> grant index, valid).

Verification
REQ-035 Reset release, iinit_fin after 20 cycles -> one oinit_req pulse, IDLE, no port served before init.
REQ-036 NPORTS=4, all ireq high, writes -> grants 0,1,2,3,0 in order, one oack each.
REQ-037 Port 1 read, ird_data=0xA5..A5 -> ordata[1]=0xA5..A5 at oack, other ordata slices unchanged.
REQ-038 REF_INTERVAL=50, port busy at expiry -> refresh issued immediately after DONE, before next grant.
REQ-039 iref_fin withheld 8 intervals -> pending saturates at 7, orefresh_miss=1 and stays set.
REQ-040 ireset_n low during OP_WAIT -> no oack, state INIT_START, oinit_req pulses again after release.
